// File: rtl/pinv_arith_pkg.sv
// Shared types and helpers for the PseudoInverse arithmetic units.
package pinv_arith_pkg;

    // Sequencing states of the multi-cycle arithmetic units.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2, evaluated at elaboration time to size counters.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational DIGIT-bit ripple slice built from a chain of full-adder cells.
// c_msb_in exposes the carry into the top bit so callers can form the signed
// overflow flag.
module adder_slice #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb_in
);

    logic [DIGIT:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign s[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i]) | (x[i] & c[i]) | (y[i] & c[i]);
    end

    assign co       = c[DIGIT];
    assign c_msb_in = c[DIGIT-1];

endmodule

// File: rtl/serial_adder_n.sv
// Digit-serial add/subtract unit with valid/ready on both sides.
// Each RUN cycle consumes DIGIT bits of the operands LSB-first; the result
// register fills from the top so the last digit lands in place.
// Optional feature: define SERIAL_ADDER_OVF_EN to add the signed overflow
// output ovf.
import pinv_arith_pkg::*;

module serial_adder_n #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (clog2(NDIG) < 1) ? 1 : clog2(NDIG);

    if ((DIGIT < 1) || (DIGIT > WIDTH)) begin : g_bad_digit
        $error("serial_adder_n: DIGIT must lie in 1..WIDTH");
    end
    if ((WIDTH % DIGIT) != 0) begin : g_bad_width
        $error("serial_adder_n: WIDTH must be a multiple of DIGIT");
    end

    state_t           state, next_state;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] op_a, op_b;
    logic [DIGIT-1:0] slice_s;
    logic             slice_co;
    logic             last;
    logic [WIDTH-1:0] sum_shift;

    assign last      = (cnt == CW'(NDIG - 1));
    // New digit enters at the top while older digits move down.
    assign sum_shift = (sum >> DIGIT) | (WIDTH'(slice_s) << (WIDTH - DIGIT));

`ifdef SERIAL_ADDER_OVF_EN
    logic slice_cm;

    adder_slice #(.DIGIT(DIGIT)) u_slice (
        .x        (op_a[DIGIT-1:0]),
        .y        (op_b[DIGIT-1:0]),
        .cin      (carry),
        .s        (slice_s),
        .co       (slice_co),
        .c_msb_in (slice_cm)
    );
`else
    adder_slice #(.DIGIT(DIGIT)) u_slice (
        .x        (op_a[DIGIT-1:0]),
        .y        (op_b[DIGIT-1:0]),
        .cin      (carry),
        .s        (slice_s),
        .co       (slice_co),
        .c_msb_in ()
    );
`endif

    // State register; reset wins over any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state logic for IDLE -> RUN -> DONE -> IDLE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid)  next_state = RUN;
            RUN:     if (last)      next_state = DONE;
            DONE:    if (out_ready) next_state = IDLE;
            default:                next_state = IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Datapath: capture operands on accept, then shift one digit per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            carry <= 1'b0;
            op_a  <= '0;
            op_b  <= '0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    op_a  <= a;
                    // Subtraction as A + ~B + 1: the +1 rides in on the carry.
                    op_b  <= sub ? ~b : b;
                    carry <= sub;
                    cnt   <= '0;
                end
                RUN: begin
                    op_a  <= op_a >> DIGIT;
                    op_b  <= op_b >> DIGIT;
                    sum   <= sum_shift;
                    carry <= slice_co;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        cout <= slice_co;
`ifdef SERIAL_ADDER_OVF_EN
                        ovf  <= slice_cm ^ slice_co;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_n.sv
// Self-checking bench for serial_adder_n: three instances (DIGIT=4, 16, 1)
// share stimulus and are compared against an arithmetic reference model.
`timescale 1ns/1ps
module tb_serial_adder_n;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          out_ready;
    logic          sub;
    logic [W-1:0]  a, b;
    logic [2:0]    in_ready, out_valid, cout;
    logic [W-1:0]  sum [3];
`ifdef SERIAL_ADDER_OVF_EN
    logic [2:0]    ovf;
`endif

    int checks   = 0;
    int failures = 0;
    int lat_exp [3] = '{4, 1, 16};

    always #5 clk = ~clk;

`ifdef SERIAL_ADDER_OVF_EN
    serial_adder_n #(.WIDTH(W), .DIGIT(4)) u_d4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid[0]), .out_ready(out_ready),
        .sum(sum[0]), .ovf(ovf[0]), .cout(cout[0]));
    serial_adder_n #(.WIDTH(W), .DIGIT(16)) u_d16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid[1]), .out_ready(out_ready),
        .sum(sum[1]), .ovf(ovf[1]), .cout(cout[1]));
    serial_adder_n #(.WIDTH(W), .DIGIT(1)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[2]),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid[2]), .out_ready(out_ready),
        .sum(sum[2]), .ovf(ovf[2]), .cout(cout[2]));
`else
    serial_adder_n #(.WIDTH(W), .DIGIT(4)) u_d4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid[0]), .out_ready(out_ready),
        .sum(sum[0]), .cout(cout[0]));
    serial_adder_n #(.WIDTH(W), .DIGIT(16)) u_d16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid[1]), .out_ready(out_ready),
        .sum(sum[1]), .cout(cout[1]));
    serial_adder_n #(.WIDTH(W), .DIGIT(1)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[2]),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid[2]), .out_ready(out_ready),
        .sum(sum[2]), .cout(cout[2]));
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Wait (bounded) until every instance reports in_ready.
    task automatic wait_idle();
        int w;
        w = 0;
        while (in_ready !== 3'b111 && w < 60) begin
            @(posedge clk); #1;
            w++;
        end
        if (w >= 60) chk("idle_timeout", 32'(in_ready), 32'h7);
    endtask

    // Issue one operation, check latency and results; optionally drain it.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic ts, input bit drain);
        logic [W-1:0] e_sum;
        logic         e_cout;
        logic         e_ovf;
        int           lat [3];
        bit           all_seen;

        if (ts) begin
            e_sum  = ta - tb_v;
            e_cout = (ta >= tb_v);
            e_ovf  = (ta[W-1] != tb_v[W-1]) && (e_sum[W-1] != ta[W-1]);
        end else begin
            e_sum  = ta + tb_v;
            e_cout = ((32'(ta) + 32'(tb_v)) >= 32'h1_0000);
            e_ovf  = (ta[W-1] == tb_v[W-1]) && (e_sum[W-1] != ta[W-1]);
        end

        wait_idle();
        a = ta; b = tb_v; sub = ts; in_valid = 1'b1;
        @(posedge clk); #1;
        // Scramble inputs after the accept edge: they must not matter now.
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
        lat = '{-1, -1, -1};
        for (int k = 0; k <= 40; k++) begin
            all_seen = 1'b1;
            for (int i = 0; i < 3; i++) begin
                if (out_valid[i] && lat[i] < 0) lat[i] = k;
                if (lat[i] < 0) all_seen = 1'b0;
            end
            if (all_seen) break;
            @(posedge clk); #1;
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("latency[%0d]", i), 32'(lat[i]), 32'(lat_exp[i]));
            chk($sformatf("sum[%0d]", i),     32'(sum[i]), 32'(e_sum));
            chk($sformatf("cout[%0d]", i),    32'(cout[i]), 32'(e_cout));
`ifdef SERIAL_ADDER_OVF_EN
            chk($sformatf("ovf[%0d]", i),     32'(ovf[i]), 32'(e_ovf));
`endif
        end
        if (!drain) return;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("drain_in_ready", 32'(in_ready), 32'h7);
        chk("drain_out_valid", 32'(out_valid), 32'h0);
    endtask

    initial begin
        logic [W-1:0] held [3];
        int           stray;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sub = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'h7);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_cout", 32'(cout), 32'h0);
        for (int i = 0; i < 3; i++) chk("rst_sum", 32'(sum[i]), 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases
        run_op(16'h1234, 16'h4321, 1'b0, 1'b1);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b1);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b1);
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1);
        run_op(16'h0007, 16'h0005, 1'b1, 1'b1);
        run_op(16'h8000, 16'h0001, 1'b1, 1'b1);
        run_op(16'h0000, 16'h0000, 1'b1, 1'b1);

        // Backpressure: hold result for 5 cycles while a competing request waits.
        run_op(16'hABCD, 16'h1357, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) held[i] = sum[i];
        a = 16'h1111; b = 16'h2222; sub = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("bp_out_valid", 32'(out_valid), 32'h7);
            chk("bp_in_ready", 32'(in_ready), 32'h0);
            for (int i = 0; i < 3; i++) chk("bp_sum_hold", 32'(sum[i]), 32'(held[i]));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_release_in_ready", 32'(in_ready), 32'h7);
        chk("bp_release_out_valid", 32'(out_valid), 32'h0);
        for (int i = 0; i < 3; i++) chk("idle_sum_hold", 32'(sum[i]), 32'(held[i]));

        // Random operations
        for (int n = 0; n < 25; n++)
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b1);

        // Reset two edges into RUN: everything clears, no stale result.
        wait_idle();
        a = 16'h1234; b = 16'h4321; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_in_ready", 32'(in_ready), 32'h7);
        chk("midrst_out_valid", 32'(out_valid), 32'h0);
        chk("midrst_cout", 32'(cout), 32'h0);
        for (int i = 0; i < 3; i++) chk("midrst_sum", 32'(sum[i]), 32'h0);
        out_ready = 1'b1;
        stray = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (out_valid !== 3'b000) stray++;
        end
        out_ready = 1'b0;
        chk("midrst_no_stale", 32'(stray), 32'h0);

        // Unit is usable again after the abort.
        run_op(16'h1234, 16'h4321, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
